j_stream_serializer: RTL and testbench

Parallel-to-serial feeder that sits directly upstream of the sequence detector and drives its one-bit serial input `J`. It accepts bytes over a valid/ready handshake, buffers one byte behind the one being shifted, and emits bits on consecutive cycles with no gap between back-to-back bytes. This lets patterns such as 10000001 span byte boundaries. When no data is pending it drives a constant idle level.

---
 rtl/j_stream_serializer.sv | 99 +++++++++
 tb/tb_j_stream_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/j_stream_serializer.sv
// j_stream_serializer: parallel-to-serial feeder for the sequence detector.
// Accepts words over valid/ready, keeps one word buffered, and shifts bits
// out on J with no gap between back-to-back words.
//
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-high reset
//   din      in  : WIDTH-bit word to serialize
//   in_valid in  : din is valid this cycle
//   ready    out : a word can be accepted this cycle
//   J        out : serial bit stream (IDLE_BIT when nothing is shifting)
//   busy     out : a word is being shifted
//   sof      out : high during the first bit of every word
module j_stream_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             ready,
    output logic             J,
    output logic             busy,
    output logic             sof
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam int OUT = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic             hold_v;
    logic             active;
    logic             accept;

    assign active = (state == SHIFT);
    assign ready  = !hold_v && !rst;
    assign accept = in_valid && ready;

    assign busy = active;
    assign sof  = active && (cnt == '0);
    assign J    = active ? sh[OUT] : IDLE_BIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            hold   <= '0;
            hold_v <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sh    <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        if (MSB_FIRST)
                            sh <= {sh[WIDTH-2:0], 1'b0};
                        else
                            sh <= {1'b0, sh[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (accept) begin
                            hold   <= din;
                            hold_v <= 1'b1;
                        end
                    end else begin
                        // Last bit: chain the next word in with no idle gap.
                        cnt <= '0;
                        if (hold_v) begin
                            sh     <= hold;
                            hold_v <= 1'b0;
                        end else if (accept) begin
                            sh <= din;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_j_stream_serializer.sv
// tb_j_stream_serializer: directed checks of the serializer, MSB-first
// instance (idle 0) and LSB-first instance (idle 1).
module tb_j_stream_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din1, din2;
    logic       iv1, iv2;
    logic       rdy1, rdy2;
    logic       j1, j2;
    logic       busy1, busy2;
    logic       sof1, sof2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    j_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din1), .in_valid(iv1),
        .ready(rdy1), .J(j1), .busy(busy1), .sof(sof1)
    );

    j_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .in_valid(iv2),
        .ready(rdy2), .J(j2), .busy(busy2), .sof(sof2)
    );

    typedef struct {
        logic       lsb;
        logic [7:0] din;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.lsb) begin iv2 = 1'b1; din2 = v.din; end
        else begin iv1 = 1'b1; din1 = v.din; end
        chk("vec_ready_idle", v.lsb ? rdy2 : rdy1, 1);
        @(negedge clk);
        iv1 = 1'b0;
        iv2 = 1'b0;
        chk("vec_ready_first_bit", v.lsb ? rdy2 : rdy1, 1);
        for (int i = 0; i < 8; i++) begin
            chk("vec_J", v.lsb ? j2 : j1, v.seq[7-i]);
            chk("vec_sof", v.lsb ? sof2 : sof1, i == 0);
            chk("vec_busy", v.lsb ? busy2 : busy1, 1);
            @(negedge clk);
        end
        chk("vec_idle_J", v.lsb ? j2 : j1, v.lsb);
        chk("vec_idle_busy", v.lsb ? busy2 : busy1, 0);
    endtask

    logic [15:0] pair_exp;
    logic [23:0] bp_exp;
    logic [7:0]  words[3];
    int          xfer[3];
    int          idx;
    logic        pending;

    initial begin
        vecs[0] = '{1'b0, 8'h81, 8'b1000_0001};
        vecs[1] = '{1'b0, 8'hA5, 8'b1010_0101};
        vecs[2] = '{1'b0, 8'h3C, 8'b0011_1100};
        vecs[3] = '{1'b0, 8'h01, 8'b0000_0001};
        vecs[4] = '{1'b0, 8'hC8, 8'b1100_1000};
        vecs[5] = '{1'b1, 8'h01, 8'b1000_0000};
        vecs[6] = '{1'b1, 8'h0E, 8'b0111_0000};
        vecs[7] = '{1'b1, 8'hC8, 8'b0001_0011};

        // Reset with a word offered: nothing may transfer.
        rst  = 1'b1;
        iv1  = 1'b1;
        din1 = 8'hFF;
        iv2  = 1'b1;
        din2 = 8'hFF;
        @(negedge clk);
        chk("rst_ready_low", rdy1, 0);
        chk("rst_busy", busy1, 0);
        @(negedge clk);
        chk("rst_J", j1, 0);
        chk("rst_J2_idle", j2, 1);
        chk("rst_ready2_low", rdy2, 0);
        rst = 1'b0;
        iv1 = 1'b0;
        iv2 = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy1, 1);
        chk("post_rst_busy", busy1, 0);
        chk("post_rst_J", j1, 0);
        chk("post_rst_sof", sof1, 0);
        chk("post_rst_J2", j2, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Gapless pair: 80 then 01 back to back.
        pair_exp = 16'b1000_0000_0000_0001;
        @(negedge clk);
        iv1  = 1'b1;
        din1 = 8'h80;
        @(negedge clk);
        din1 = 8'h01;
        for (int c = 1; c <= 16; c++) begin
            chk("pair_J", j1, pair_exp[16-c]);
            chk("pair_sof", sof1, c == 1 || c == 9);
            chk("pair_ready", rdy1, !(c >= 2 && c <= 8));
            chk("pair_busy", busy1, 1);
            if (c == 1) begin
                @(negedge clk);
                iv1 = 1'b0;
                continue;
            end
            @(negedge clk);
        end
        chk("pair_end_busy", busy1, 0);
        chk("pair_end_J", j1, 0);

        // Backpressure: three words with in_valid held.
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hF0;
        bp_exp   = 24'hA5_3C_F0;
        foreach (xfer[i]) xfer[i] = -1;
        idx     = 0;
        pending = 1'b0;
        @(negedge clk);
        iv1  = 1'b1;
        din1 = words[0];
        for (int c = 0; c <= 26; c++) begin
            if (pending) begin
                xfer[idx] = c - 1;
                idx++;
                if (idx == 3) iv1 = 1'b0;
                else din1 = words[idx];
            end
            if (c >= 1 && c <= 24) begin
                chk("bp_J", j1, bp_exp[24-c]);
                chk("bp_busy", busy1, 1);
            end
            if (c == 25) chk("bp_end_busy", busy1, 0);
            pending = iv1 && rdy1;
            @(negedge clk);
        end
        chk("bp_count", idx, 3);
        chk("bp_edge0", xfer[0], 0);
        chk("bp_edge1", xfer[1], 1);
        chk("bp_edge2", xfer[2], 9);

        // Reset mid-word with the holding register full.
        @(negedge clk);
        iv1  = 1'b1;
        din1 = 8'hFF;
        @(negedge clk);
        din1 = 8'h55;
        @(negedge clk);
        iv1 = 1'b0;
        chk("mid_hold_full", dut.hold_v, 1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_4th_bit_J", j1, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_J", j1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_hold_v", dut.hold_v, 0);
        chk("mid_rst_ready", rdy1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_ready", rdy1, 1);
        chk("mid_after_J", j1, 0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
